// File: rtl/acq_ring_buffer.sv
// Acquisition ring buffer: show-ahead FIFO with a drop-new or overwrite-oldest policy on full, and sticky ovf/udf flags.
// Defining ACQ_BUF_HWM_EN adds the hwm (high-water mark) output and its register.
module acq_ring_buffer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned AFULL_LVL = 12,
  parameter int unsigned OVERWRITE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              flush,
  input  logic              ovf_clr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              afull,
  output logic [ADDR_W:0]   level,
`ifdef ACQ_BUF_HWM_EN
  output logic [ADDR_W:0]   hwm,
`endif
  output logic              ovf,
  output logic              udf
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned LVL_W = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_LVL = LVL_W'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_THR = LVL_W'(AFULL_LVL);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr_nxt;
  logic [ADDR_W-1:0] rd_ptr_nxt;
  logic [ADDR_W:0]   level_nxt;
  logic              ovf_nxt;
  logic              udf_nxt;
  logic              mem_we;
  logic              do_pop;
  logic              ovf_ev;
  logic              udf_ev;
  logic              is_empty;
  logic              is_full;

  // Status is decoded from the registered level only.
  assign is_empty = (level == '0);
  assign is_full  = (level == DEPTH_LVL);
  assign rd_valid = !is_empty;
  assign full     = is_full;
  assign afull    = (level >= AFULL_THR);
  assign rd_data  = mem[rd_ptr];

  // Pointer/level/flag next-state; a pop on a full buffer frees the slot for a same-cycle push.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    level_nxt  = level;
    mem_we     = 1'b0;
    do_pop     = 1'b0;
    ovf_ev     = 1'b0;
    udf_ev     = 1'b0;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      level_nxt  = '0;
    end else begin
      do_pop = rd_en && !is_empty;
      udf_ev = rd_en && is_empty;
      if (do_pop) begin
        rd_ptr_nxt = rd_ptr + ADDR_W'(1);
      end
      if (wr_en) begin
        if (!is_full || do_pop) begin
          mem_we     = 1'b1;
          wr_ptr_nxt = wr_ptr + ADDR_W'(1);
          if (!do_pop) begin
            level_nxt = level + LVL_W'(1);
          end
        end else begin
          ovf_ev = 1'b1;
          if (OVERWRITE != 0) begin
            mem_we     = 1'b1;
            wr_ptr_nxt = wr_ptr + ADDR_W'(1);
            rd_ptr_nxt = rd_ptr + ADDR_W'(1);
          end
        end
      end else if (do_pop) begin
        level_nxt = level - LVL_W'(1);
      end
    end
    // A new event in the clearing cycle keeps its flag set.
    ovf_nxt = ovf_ev || (ovf && !ovf_clr);
    udf_nxt = udf_ev || (udf && !ovf_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      level  <= level_nxt;
      ovf    <= ovf_nxt;
      udf    <= udf_nxt;
    end
  end

  // Sample storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr] <= wr_data;
    end
  end

`ifdef ACQ_BUF_HWM_EN
  logic [ADDR_W:0] hwm_nxt;

  always_comb begin
    hwm_nxt = hwm;
    if (ovf_clr) begin
      hwm_nxt = level_nxt;
    end else if (level_nxt > hwm) begin
      hwm_nxt = level_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm <= '0;
    end else begin
      hwm <= hwm_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_acq_ring_buffer.sv
// Bench for acq_ring_buffer: drop-new and overwrite instances driven in lockstep, checked every cycle against queue models.
module tb_acq_ring_buffer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AFL   = 12;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        wr_en   = 1'b0;
  logic [31:0] wr_data = '0;
  logic        rd_en   = 1'b0;
  logic        flush   = 1'b0;
  logic        ovf_clr = 1'b0;

  logic [31:0] rdat [2];
  logic        rval [2];
  logic        fullo [2];
  logic        afullo [2];
  logic [4:0]  lvl [2];
  logic        ovfo [2];
  logic        udfo [2];
`ifdef ACQ_BUF_HWM_EN
  logic [4:0]  hwmo [2];
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    acq_ring_buffer #(
      .DATA_W(32), .ADDR_W(4), .AFULL_LVL(AFL), .OVERWRITE(g)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
      .rd_en(rd_en), .flush(flush), .ovf_clr(ovf_clr),
      .rd_data(rdat[g]), .rd_valid(rval[g]), .full(fullo[g]),
      .afull(afullo[g]), .level(lvl[g]),
`ifdef ACQ_BUF_HWM_EN
      .hwm(hwmo[g]),
`endif
      .ovf(ovfo[g]), .udf(udfo[g])
    );
  end

  // Reference model: instance 0 drops new samples on full, instance 1 overwrites the oldest.
  logic [31:0] mq [2][$];
  bit          m_ovf [2];
  bit          m_udf [2];
  int          m_hwm [2];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      bit was_full;
      bit popped;
      bit ev_o;
      bit ev_u;
      if (!rst_n) begin
        mq[k].delete();
        m_ovf[k] = 1'b0;
        m_udf[k] = 1'b0;
        m_hwm[k] = 0;
      end else begin
        ev_o = 1'b0;
        ev_u = 1'b0;
        popped = 1'b0;
        if (flush) begin
          mq[k].delete();
        end else begin
          was_full = (mq[k].size() == DEPTH);
          if (rd_en) begin
            if (mq[k].size() == 0) ev_u = 1'b1;
            else begin
              void'(mq[k].pop_front());
              popped = 1'b1;
            end
          end
          if (wr_en) begin
            if (was_full && !popped) begin
              ev_o = 1'b1;
              if (k == 1) begin
                void'(mq[k].pop_front());
                mq[k].push_back(wr_data);
              end
            end else begin
              mq[k].push_back(wr_data);
            end
          end
        end
        m_ovf[k] = ev_o || (m_ovf[k] && !ovf_clr);
        m_udf[k] = ev_u || (m_udf[k] && !ovf_clr);
        if (ovf_clr) m_hwm[k] = mq[k].size();
        else if (mq[k].size() > m_hwm[k]) m_hwm[k] = mq[k].size();
      end
    end
  end

  function automatic void chk(input int k, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[ovw=%0d] got=0x%0h want=0x%0h t=%0t", nm, k, act, exp, $time);
    end
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int n;
      n = mq[k].size();
      chk(k, "level", 64'(lvl[k]), 64'(n));
      chk(k, "rd_valid", 64'(rval[k]), 64'(n != 0));
      chk(k, "full", 64'(fullo[k]), 64'(n == DEPTH));
      chk(k, "afull", 64'(afullo[k]), 64'(n >= AFL));
      chk(k, "ovf", 64'(ovfo[k]), 64'(m_ovf[k]));
      chk(k, "udf", 64'(udfo[k]), 64'(m_udf[k]));
      if (n != 0) chk(k, "rd_data", 64'(rdat[k]), 64'(mq[k][0]));
`ifdef ACQ_BUF_HWM_EN
      chk(k, "hwm", 64'(hwmo[k]), 64'(m_hwm[k]));
`endif
    end
  end

  task automatic step(input logic w, input logic [31:0] d, input logic r, input logic f, input logic c);
    wr_en = w; wr_data = d; rd_en = r; flush = f; ovf_clr = c;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic pin_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk(k, {tag, "_level"}, 64'(lvl[k]), 64'd0);
      chk(k, {tag, "_rd_valid"}, 64'(rval[k]), 64'd0);
      chk(k, {tag, "_full"}, 64'(fullo[k]), 64'd0);
      chk(k, {tag, "_afull"}, 64'(afullo[k]), 64'd0);
      chk(k, {tag, "_ovf"}, 64'(ovfo[k]), 64'd0);
      chk(k, {tag, "_udf"}, 64'(udfo[k]), 64'd0);
`ifdef ACQ_BUF_HWM_EN
      chk(k, {tag, "_hwm"}, 64'(hwmo[k]), 64'd0);
`endif
    end
  endtask

  initial begin
    logic [31:0] d;
    repeat (3) @(negedge clk);
    pin_zero("reset");
    rst_n = 1'b1;

    // Fill with 1..16; afull rises on the 12th push.
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
      if (i == 11) chk(0, "pin_afull_at_11", 64'(afullo[0]), 64'd0);
      if (i == 12) chk(0, "pin_afull_at_12", 64'(afullo[0]), 64'd1);
    end
    chk(0, "pin_full", 64'(fullo[0]), 64'd1);
    chk(0, "pin_level16", 64'(lvl[0]), 64'd16);
    chk(0, "pin_head1", 64'(rdat[0]), 64'h1);

    // Push on full: drop vs overwrite.
    step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    chk(0, "pin_ovf_drop", 64'(ovfo[0]), 64'd1);
    chk(0, "pin_level_drop", 64'(lvl[0]), 64'd16);
    chk(0, "pin_head_drop", 64'(rdat[0]), 64'h1);
    chk(1, "pin_ovf_ovw", 64'(ovfo[1]), 64'd1);
    chk(1, "pin_head_ovw", 64'(rdat[1]), 64'h2);
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) begin
        chk(0, "pin_last_drop", 64'(rdat[0]), 64'h10);
        chk(1, "pin_last_ovw", 64'(rdat[1]), 64'hDEADBEEF);
      end
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    chk(0, "pin_drained", 64'(rval[0]), 64'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk(0, "pin_ovf_clr", 64'(ovfo[0]), 64'd0);

    // Push+pop while full keeps level and does not overflow.
    for (int i = 0; i < 16; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0);
    chk(0, "pin_full_pushpop_lvl", 64'(lvl[0]), 64'd16);
    chk(0, "pin_full_pushpop_ovf", 64'(ovfo[0]), 64'd0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Level 5, 20 cycles of simultaneous push/pop wrap both pointers.
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
    chk(0, "pin_level5", 64'(lvl[0]), 64'd5);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Empty push with rd_en: write accepted, read ignored, udf set.
    step(1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0);
    chk(0, "pin_udf", 64'(udfo[0]), 64'd1);
    chk(0, "pin_level1", 64'(lvl[0]), 64'd1);
    chk(0, "pin_a5", 64'(rdat[0]), 64'hA5A5A5A5);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk(0, "pin_udf_clr", 64'(udfo[0]), 64'd0);

    // Level 9, flush with a same-cycle push.
    for (int i = 0; i < 8; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    chk(0, "pin_level9", 64'(lvl[0]), 64'd9);
    step(1'b1, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0);
    chk(0, "pin_flush_lvl", 64'(lvl[0]), 64'd0);
    chk(0, "pin_flush_valid", 64'(rval[0]), 64'd0);

`ifdef ACQ_BUF_HWM_EN
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk(0, "pin_hwm11", 64'(hwmo[0]), 64'd11);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk(0, "pin_hwm2", 64'(hwmo[0]), 64'd2);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
`endif

    // Randomized traffic, alternating push-heavy and pop-heavy segments.
    for (int s = 0; s < 8; s++) begin
      int wp;
      wp = (s % 2 == 0) ? 75 : 30;
      for (int i = 0; i < 250; i++) begin
        step(($urandom % 100) < wp, $urandom, ($urandom % 100) < (100 - wp),
             ($urandom % 100) < 1, ($urandom % 100) < 3);
      end
    end

    // Asynchronous reset mid-burst with both flags set.
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    chk(0, "pin_pre_reset_ovf", 64'(ovfo[0]), 64'd1);
    d = 32'h0BADF00D;
    wr_en = 1'b1; wr_data = d;
    #2 rst_n = 1'b0;
    #1 pin_zero("midreset");
    #4 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    chk(0, "pin_first_push_lvl", 64'(lvl[0]), 64'd1);
    chk(0, "pin_first_push_data", 64'(rdat[0]), 64'(d));
    for (int i = 0; i < 40; i++) step($urandom % 2, $urandom, $urandom % 2, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/acq_ring_buffer.md
ACQ_RING_BUFFER -- requirements
Module: acq_ring_buffer

Interface
REQ-001 Parameter DATA_W, default 32, sample width in bits.
REQ-002 Parameter ADDR_W, default 4, pointer width; depth DEPTH = 2**ADDR_W entries.
REQ-003 Parameter AFULL_LVL, default 12, almost-full threshold in entries (1..DEPTH).
REQ-004 Parameter OVERWRITE, default 0; 0 = drop-new on full, 1 = overwrite-oldest on full.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 wr_en  input  1  push request for wr_data.
REQ-008 wr_data  input  DATA_W  sample to push.
REQ-009 rd_en  input  1  pop request for the current head entry.
REQ-010 flush  input  1  synchronous discard of all stored entries.
REQ-011 ovf_clr  input  1  synchronous clear of the ovf and udf flags.
REQ-012 rd_data  output  DATA_W  head entry, combinational from the array (show-ahead).
REQ-013 rd_valid  output  1  high when level != 0.
REQ-014 full  output  1  high when level == DEPTH.
REQ-015 afull  output  1  high when level >= AFULL_LVL.
REQ-016 level  output  ADDR_W+1  number of stored entries, 0..DEPTH.
REQ-017 ovf  output  1  sticky: a push occurred while full.
REQ-018 udf  output  1  sticky: rd_en asserted while empty.
REQ-019 hwm  output  ADDR_W+1  high-water mark; present only when ACQ_BUF_HWM_EN is defined.

Function
REQ-020 Storage SHALL be a DEPTH x DATA_W register array with wr_ptr and rd_ptr of ADDR_W bits, wrapping from DEPTH-1 to 0.
REQ-021 rd_data SHALL equal mem[rd_ptr] in the same cycle; value is don't-care while rd_valid is 0.
REQ-022 Pop (rd_en & rd_valid) SHALL advance rd_ptr by 1 and decrement level at the next edge.
REQ-023 Push when not full SHALL write mem[wr_ptr], advance wr_ptr and increment level at the next edge.
REQ-024 Push and pop in the same cycle with 0 < level < DEPTH SHALL perform both; level unchanged.
REQ-025 Push and pop when full SHALL perform both (pop frees the slot); level stays DEPTH; ovf not set.
REQ-026 Push and rd_en when empty SHALL accept the write, ignore the read, set udf; level becomes 1; no bypass to rd_data in that cycle.
REQ-027 Push without pop when full and OVERWRITE=0 SHALL drop the sample, leave pointers/level/array unchanged, and set ovf.
REQ-028 Push without pop when full and OVERWRITE=1 SHALL write mem[wr_ptr], advance wr_ptr and rd_ptr, keep level = DEPTH, and set ovf.
REQ-029 rd_en while empty SHALL leave rd_ptr and level unchanged and set udf.
REQ-030 flush SHALL zero wr_ptr, rd_ptr and level at the next edge and take priority over wr_en and rd_en in that cycle; array contents not cleared; ovf/udf unaffected.
REQ-031 ovf_clr SHALL clear ovf and udf at the next edge; a new overflow/underflow event in the same cycle SHALL win (flag stays 1).
REQ-032 full, afull and rd_valid SHALL be decoded from registered level, with no combinational path from wr_en/rd_en.

Reset
REQ-033 Assertion of rst_n low SHALL immediately force wr_ptr=0, rd_ptr=0, level=0, ovf=0, udf=0, hwm=0, hence rd_valid=0, full=0, afull=0.
REQ-034 Array contents SHALL NOT be reset; reset mid-operation discards all stored entries.
REQ-035 Deassertion of rst_n SHALL be usable asynchronously; first accepted push is on the first rising edge with rst_n high.

Configuration
REQ-036 With macro ACQ_BUF_HWM_EN defined, hwm SHALL hold the maximum level since reset or last ovf_clr, updated at each edge to max(hwm, next level); ovf_clr loads hwm with the next level.
REQ-037 Without ACQ_BUF_HWM_EN, the hwm port and its register SHALL be absent; all other behaviour identical.

Verification
REQ-038 Defaults; push 0x00000001..0x00000010 (16 cycles) -> full=1, level=16, afull asserted after 12th push; 16 pops return 1..16 in order, rd_valid drops after last.
REQ-039 OVERWRITE=0, full, push 0xDEADBEEF -> ovf=1, level=16, head still 0x00000001; OVERWRITE=1 same stimulus -> head 0x00000002, last popped 0xDEADBEEF.
REQ-040 Level 5, simultaneous push/pop for 20 cycles -> level stays 5, pointers wrap, data order preserved.
REQ-041 Empty, rd_en=1 with wr_en=1, wr_data=0xA5A5A5A5 -> udf=1, level=1, rd_data=0xA5A5A5A5 next cycle; ovf_clr -> udf=0.
REQ-042 Level 9, flush and wr_en same cycle -> level=0, rd_valid=0, write discarded; rst_n pulse mid-burst -> all outputs zero within the same cycle.
REQ-043 ACQ_BUF_HWM_EN defined: fill to 11, drain to 2 -> hwm=11; ovf_clr -> hwm=2.
